// File: rtl/io_debug_port.sv
// Wishbone I/O debug port: byte FIFO fed through a data register, plus a status register.
// Optional interrupt output enabled by defining IO_DBG_IRQ_EN.
module io_debug_port #(
    parameter logic [15:0] BASE_ADDR  = 16'h00B7,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        byte_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [7:0]  dbg_dat_o,
    output logic        dbg_vld_o,
    input  logic        dbg_rdy_i
`ifdef IO_DBG_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0]   DATA_ADDR = BASE_ADDR;
    localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WORD_MAX  = CW'(FIFO_DEPTH - 2);

`ifdef IO_DBG_IRQ_EN
    localparam logic IRQ_FLAG = 1'b1;
`else
    localparam logic IRQ_FLAG = 1'b0;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_p1;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          ovf;
    logic          armed;
    logic [7:0]    last_byte;

    logic          hit_data;
    logic          hit_stat;
    logic          ack_nxt;
    logic          wr_data;
    logic          fits;
    logic          push_one;
    logic          push_two;
    logic          ovf_set;
    logic          ovf_clr;
    logic          empty;
    logic          full;
    logic          pop;
    logic [15:0]   status;
    logic [15:0]   rd_data;

    // armed holds off the first acknowledge until one edge after reset release.
    always_comb begin
        hit_data  = (adr_i == DATA_ADDR);
        hit_stat  = (adr_i == STAT_ADDR);
        ack_nxt   = stb_i & (hit_data | hit_stat) & ~ack_o & armed;
        wr_data   = ack_nxt & we_i & hit_data;
        // Space is judged on the count before this cycle's pop.
        fits      = byte_i ? (count < DEPTH_C) : (count <= WORD_MAX);
        push_one  = wr_data & fits & byte_i;
        push_two  = wr_data & fits & ~byte_i;
        ovf_set   = wr_data & ~fits;
        ovf_clr   = ack_nxt & we_i & hit_stat & dat_i[15];
        empty     = (count == '0);
        full      = (count == DEPTH_C);
        pop       = ~empty & dbg_rdy_i;
        wr_ptr_p1 = wr_ptr + PW'(1);
        count_nxt = count + CW'(push_one) + (push_two ? CW'(2) : CW'(0)) - CW'(pop);
        status    = {ovf, IRQ_FLAG, 4'b0000, empty, full, 8'(count)};
        rd_data   = hit_data ? {8'h00, last_byte} : status;
    end

    assign dbg_vld_o = ~empty;
    assign dbg_dat_o = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed <= 1'b0;
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            armed <= 1'b1;
            ack_o <= ack_nxt;
            dat_o <= (ack_nxt & ~we_i) ? rd_data : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            last_byte <= 8'h00;
        end else begin
            count <= count_nxt;
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_one) begin
                wr_ptr    <= wr_ptr_p1;
                last_byte <= dat_i[7:0];
            end else if (push_two) begin
                wr_ptr    <= wr_ptr + PW'(2);
                last_byte <= dat_i[15:8];
            end
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_one | push_two)
            mem[wr_ptr] <= dat_i[7:0];
        if (push_two)
            mem[wr_ptr_p1] <= dat_i[15:8];
    end

`ifdef IO_DBG_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            irq_o <= 1'b0;
        else
            irq_o <= ~empty | ovf;
    end
`endif

endmodule

// File: tb/tb_io_debug_port.sv
// Directed self-checking bench for io_debug_port: vector table plus multi-cycle corner sequences.
module tb_io_debug_port;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] adr_i = '0;
    logic [15:0] dat_i = '0;
    logic [15:0] dat_o;
    logic        we_i = 1'b0;
    logic        byte_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic [7:0]  dbg_dat_o;
    logic        dbg_vld_o;
    logic        dbg_rdy_i = 1'b0;
`ifdef IO_DBG_IRQ_EN
    logic        irq_o;
    localparam logic [15:0] IRQ_BIT = 16'h4000;
`else
    localparam logic [15:0] IRQ_BIT = 16'h0000;
`endif

    localparam logic [15:0] DATA = 16'h00B7;
    localparam logic [15:0] STAT = 16'h00B8;

    io_debug_port dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .we_i      (we_i),
        .byte_i    (byte_i),
        .stb_i     (stb_i),
        .ack_o     (ack_o),
        .dbg_dat_o (dbg_dat_o),
        .dbg_vld_o (dbg_vld_o),
        .dbg_rdy_i (dbg_rdy_i)
`ifdef IO_DBG_IRQ_EN
        ,
        .irq_o     (irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic        byt;
        logic [15:0] adr;
        logic [15:0] dat;
        logic        rdy;
        logic        exp_ack;
        logic [15:0] exp_rd;
        logic        exp_vld;
        logic [7:0]  exp_head;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic byt, input logic [15:0] adr,
                                input logic [15:0] dat, input logic rdy, input logic exp_ack,
                                input logic [15:0] exp_rd, input logic exp_vld,
                                input logic [7:0] exp_head);
        vec_t v;
        v.we = we; v.byt = byt; v.adr = adr; v.dat = dat; v.rdy = rdy;
        v.exp_ack = exp_ack; v.exp_rd = exp_rd; v.exp_vld = exp_vld; v.exp_head = exp_head;
        return v;
    endfunction

    // One bus access; rdy is offered only on the edge where ack can rise. Bounded to 4 cycles.
    task automatic bus(input logic we, input logic byt, input logic [15:0] adr,
                       input logic [15:0] dat, input logic rdy,
                       output logic got, output logic [15:0] rd, output int lat);
        @(negedge clk_i);
        we_i = we; byte_i = byt; adr_i = adr; dat_i = dat; dbg_rdy_i = rdy; stb_i = 1'b1;
        got = 1'b0; rd = '0; lat = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk_i);
            dbg_rdy_i = 1'b0;
            lat = i + 1;
            if (ack_o) begin
                got = 1'b1;
                rd  = dat_o;
            end
        end
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic acc(input string name, input logic we, input logic byt, input logic [15:0] adr,
                       input logic [15:0] dat, input logic rdy, input logic [15:0] exp_rd);
        logic        got;
        logic [15:0] rd;
        int          lat;
        bus(we, byt, adr, dat, rdy, got, rd, lat);
        check({name, " ack"}, 16'(got), 16'h1);
        if (got)
            check({name, " rdata"}, rd, exp_rd);
    endtask

    task automatic pop_one();
        @(negedge clk_i);
        dbg_rdy_i = 1'b1;
        @(negedge clk_i);
        dbg_rdy_i = 1'b0;
    endtask

    vec_t        tbl[15];
    logic        got;
    logic [15:0] rd;
    int          lat;
    int          acks;

    initial begin
        tbl[0]  = mk(0, 0, STAT, 16'h0000, 0, 1, 16'h0200 | IRQ_BIT, 0, 8'h00);
        tbl[1]  = mk(0, 0, DATA, 16'h0000, 0, 1, 16'h0000, 0, 8'h00);
        tbl[2]  = mk(1, 1, DATA, 16'h0041, 0, 1, 16'h0000, 1, 8'h41);
        tbl[3]  = mk(0, 0, STAT, 16'h0000, 1, 1, 16'h0001 | IRQ_BIT, 0, 8'h00);
        tbl[4]  = mk(1, 0, DATA, 16'h4241, 0, 1, 16'h0000, 1, 8'h41);
        tbl[5]  = mk(0, 0, DATA, 16'h0000, 1, 1, 16'h0042, 1, 8'h42);
        tbl[6]  = mk(0, 0, STAT, 16'h0000, 1, 1, 16'h0001 | IRQ_BIT, 0, 8'h00);
        tbl[7]  = mk(0, 0, 16'h00B9, 16'h0000, 0, 0, 16'h0000, 0, 8'h00);
        tbl[8]  = mk(1, 1, 16'h00B6, 16'h0055, 0, 0, 16'h0000, 0, 8'h00);
        tbl[9]  = mk(1, 1, DATA, 16'hAA33, 0, 1, 16'h0000, 1, 8'h33);
        tbl[10] = mk(0, 0, DATA, 16'h0000, 0, 1, 16'h0033, 1, 8'h33);
        tbl[11] = mk(1, 0, DATA, 16'h5544, 1, 1, 16'h0000, 1, 8'h44);
        tbl[12] = mk(0, 0, STAT, 16'h0000, 0, 1, 16'h0002 | IRQ_BIT, 1, 8'h44);
        tbl[13] = mk(0, 0, DATA, 16'h0000, 0, 1, 16'h0055, 1, 8'h44);
        tbl[14] = mk(1, 0, STAT, 16'h7FFF, 0, 1, 16'h0000, 1, 8'h44);

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset ack_o", 16'(ack_o), 16'h0);
        check("reset dat_o", dat_o, 16'h0000);
        check("reset dbg_vld_o", 16'(dbg_vld_o), 16'h0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 15; i++) begin
            bus(tbl[i].we, tbl[i].byt, tbl[i].adr, tbl[i].dat, tbl[i].rdy, got, rd, lat);
            check($sformatf("vec%0d ack", i), 16'(got), 16'(tbl[i].exp_ack));
            if (got && tbl[i].exp_ack) begin
                check($sformatf("vec%0d latency", i), 16'(lat), 16'd1);
                check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            end
            check($sformatf("vec%0d vld", i), 16'(dbg_vld_o), 16'(tbl[i].exp_vld));
            if (tbl[i].exp_vld)
                check($sformatf("vec%0d head", i), 16'(dbg_dat_o), 16'(tbl[i].exp_head));
        end
        repeat (2) pop_one();
        check("drain vld", 16'(dbg_vld_o), 16'h0);

        // Fill to the brim, overflow, then clear the sticky flag.
        for (int i = 0; i < 8; i++)
            acc($sformatf("fill%0d", i), 1, 1, DATA, 16'h0010 + 16'(i), 0, 16'h0000);
        acc("full status", 0, 0, STAT, 16'h0, 0, 16'h0108 | IRQ_BIT);
        acc("ninth write", 1, 1, DATA, 16'h0099, 0, 16'h0000);
        acc("ovf status", 0, 0, STAT, 16'h0, 0, 16'h8108 | IRQ_BIT);
        acc("last after ovf", 0, 0, DATA, 16'h0, 0, 16'h0017);
        acc("clear ovf", 1, 0, STAT, 16'h8000, 0, 16'h0000);
        acc("cleared status", 0, 0, STAT, 16'h0, 0, 16'h0108 | IRQ_BIT);
`ifdef IO_DBG_IRQ_EN
        check("irq while queued", 16'(irq_o), 16'h1);
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fifo[%0d] vld", i), 16'(dbg_vld_o), 16'h1);
            check($sformatf("fifo[%0d] head", i), 16'(dbg_dat_o), 16'h0010 + 16'(i));
            pop_one();
        end
        check("after drain vld", 16'(dbg_vld_o), 16'h0);
`ifdef IO_DBG_IRQ_EN
        @(negedge clk_i);
        check("irq idle", 16'(irq_o), 16'h0);
`endif

        // Word write at count = DEPTH-1 with a same-cycle pop is still rejected.
        for (int i = 0; i < 7; i++)
            acc($sformatf("seven%0d", i), 1, 1, DATA, 16'h0020 + 16'(i), 0, 16'h0000);
        acc("word at 7 w/ pop", 1, 0, DATA, 16'h7766, 1, 16'h0000);
        acc("reject status", 0, 0, STAT, 16'h0, 0, 16'h8006 | IRQ_BIT);
        check("reject head", 16'(dbg_dat_o), 16'h0021);
        acc("reject last", 0, 0, DATA, 16'h0, 0, 16'h0026);
        acc("clear ovf 2", 1, 0, STAT, 16'h8000, 0, 16'h0000);
        acc("word at 6", 1, 0, DATA, 16'h7766, 0, 16'h0000);
        acc("word at 6 status", 0, 0, STAT, 16'h0, 0, 16'h0108 | IRQ_BIT);
        acc("word at 6 last", 0, 0, DATA, 16'h0, 0, 16'h0077);
        repeat (8) pop_one();
        check("drain 2 vld", 16'(dbg_vld_o), 16'h0);

        // Strobe held on a hit: ack on alternate cycles; dat_o zero between pulses.
        @(negedge clk_i);
        adr_i = STAT; we_i = 1'b0; stb_i = 1'b1;
        @(negedge clk_i); check("held c2 ack", 16'(ack_o), 16'h1);
        @(negedge clk_i); check("held c3 ack", 16'(ack_o), 16'h0);
        check("held c3 dat_o", dat_o, 16'h0000);
        @(negedge clk_i); check("held c4 ack", 16'(ack_o), 16'h1);
        stb_i = 1'b0;
        @(negedge clk_i); check("held c5 ack", 16'(ack_o), 16'h0);

        // Strobe held on a miss never acknowledges.
        adr_i = 16'h00B9; stb_i = 1'b1; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        stb_i = 1'b0;
        check("miss held acks", 16'(acks), 16'h0);

        // Asynchronous reset mid-cycle with bytes queued.
        for (int i = 0; i < 3; i++)
            acc($sformatf("pre-rst%0d", i), 1, 1, DATA, 16'h0030 + 16'(i), 0, 16'h0000);
        @(negedge clk_i);
        adr_i = STAT; we_i = 1'b0; stb_i = 1'b1;
        @(posedge clk_i);
        #2;
        check("pre-rst ack", 16'(ack_o), 16'h1);
        rst_ni = 1'b0;
        #1;
        check("rst ack_o", 16'(ack_o), 16'h0);
        check("rst dat_o", dat_o, 16'h0000);
        check("rst vld", 16'(dbg_vld_o), 16'h0);
`ifdef IO_DBG_IRQ_EN
        check("rst irq", 16'(irq_o), 16'h0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Strobe still held across release: no ack on the first edge, ack on the second.
        @(negedge clk_i); check("post-rst edge1 ack", 16'(ack_o), 16'h0);
        @(negedge clk_i); check("post-rst edge2 ack", 16'(ack_o), 16'h1);
        check("post-rst status", dat_o, 16'h0200 | IRQ_BIT);
        stb_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
